task_slot_scheduler: RTL
========================

Name: task_slot_scheduler

Overview:
- Round-robin scheduler that shares one resource port among N task requesters. The resource is, for example, the SD-card SPI engine or the seven-segment/VGA write path driven by coreController.
- Each requester raises a request, is granted exclusive ownership, and releases by pulsing done.
- A quantum counter pre-empts an owner that holds the port too long while others wait.
- Sits between the task units and the shared datapath; its one-hot grant drives the datapath input mux.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of owner index; must satisfy 2^IDW >= N.
- QUANTUM, 255, maximum consecutive grant cycles before pre-emption when another request is pending (2..2^QW-1).
- QW, 8, quantum counter width.

Ports:
- cin  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  per-requester request level; held high while the requester wants or uses the port.
- done  input  N  per-requester single-cycle release pulse; only the bit of the current owner is honoured.
- grant  output  N  registered one-hot grant; all zero when no owner.
- owner  output  IDW  index of the current or most recent owner.
- busy  output  1  high while any grant bit is high.
- expired  output  1  one-cycle pulse on the cycle the owner is pre-empted by quantum expiry.

Behaviour:
- Clock and reset: one clock (cin). Reset is synchronous and active-high. All outputs are registered.
- Reset values: grant=0, owner=0, busy=0, expired=0, state=IDLE, count=0, last pointer=N-1 (so requester 0 has first priority).
- States: IDLE, GRANT, GAP.
- Arbitration (IDLE and GAP):
  - Winner is the first set bit of req scanning (last+1) mod N upward with wrap.
  - If req==0, go to or stay in IDLE.
  - On a winner, on the next edge: grant=onehot(winner), owner=winner, busy=1, count=0, go to GRANT.
- Latency: req sampled high at edge k with no owner gives grant high after edge k.
  - The request is visible one cycle before that edge; registered 1-cycle latency.
- GRANT:
  - count increments once per cycle.
  - Release when done[owner]=1 or req[owner]=0. Next edge: grant=0, busy=0, last=owner, go to GAP.
  - Pre-emption: if count==QUANTUM-1 and (req with the owner bit masked) is non-zero, release as above and pulse expired=1 for that one cycle (the first GAP cycle).
    - Grant therefore lasts exactly QUANTUM cycles.
  - If count==QUANTUM-1 and no other request is pending: count wraps to 0, grant is held, expired stays 0.
  - Release and expiry on the same cycle: treated as a release; expired=0.
- GAP:
  - Exactly one cycle with grant=0 (bus turnaround).
  - Arbitrates in the same cycle, so the next owner's grant appears after the following edge.
  - A pre-empted requester still holding req is eligible, but at lowest priority because last=its index.
- Ignored inputs:
  - done bits of non-owners, and any done while in IDLE or GAP.
  - req changes of non-owners while in GRANT (no mid-grant re-arbitration).
- owner retains its value through GAP and IDLE.
- Reset mid-operation: on the rst edge all state returns to reset values, including the pointer; any grant drops immediately after that edge.
- Invariants: grant is always zero or one-hot; busy==|grant; expired is never high for two consecutive cycles.

Test Plan:
- Single request: rst then req=0001 → grant=0001, owner=0, busy=1 one edge later; done=0001 pulse → grant=0000 next edge, GAP one cycle, then IDLE.
- Fair rotation: req=1111 from reset, each owner pulses done on its 3rd grant cycle → grant order 0001,0010,0100,1000,0001 with exactly one zero cycle between grants; expired never 1.
- Pre-emption: QUANTUM=8, req=0101 held, no done → grant=0001 for exactly 8 cycles, expired=1 for 1 cycle, grant=0100 for 8 cycles, expired, grant=0001 again.
- Lone holder: QUANTUM=8, req=0010 only, held 30 cycles → grant=0010 continuous for 30 cycles, expired stays 0; then raise req[3] → pre-emption at the next count==7, grant=1000 after the gap.
- Release by req drop and stray done: owner 2 drops req → grant=0 next edge. done=0001 while owner is 2 → no effect.
- Reset mid-grant: grant=0100 at count 3, assert rst one cycle with req=1111 → after the rst edge grant=0, busy=0; after rst is released, grant=0001 (pointer reset).

Source files
------------

// File: rtl/task_slot_scheduler_if.sv
// task_slot_scheduler_if: request/release/grant bundle between task units and the scheduler
interface task_slot_scheduler_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] owner;
    logic           busy;
    logic           expired;
    modport master (output req, done, input grant, owner, busy, expired);
    modport slave  (input req, done, output grant, owner, busy, expired);
endinterface

// File: rtl/task_slot_scheduler.sv
// task_slot_scheduler: round-robin owner of one shared port with quantum pre-emption
module task_slot_scheduler #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int QUANTUM = 255,
    parameter int QW      = 8
) (
    input logic               cin,
    input logic               rst,
    task_slot_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t         state, state_n;
    logic [QW-1:0]  count, count_n;
    logic [IDW-1:0] last, last_n, owner, owner_n, winner, idx;
    logic [N-1:0]   grant, grant_n, own_hot;
    logic           busy, expired, expired_n, found, release_now, quantum_end, others;
    assign own_hot     = N'(1) << owner;
    assign release_now = |(bus.done & own_hot) | ~|(bus.req & own_hot);
    assign quantum_end = count == QW'(QUANTUM - 1);
    assign others      = |(bus.req & ~own_hot);
    // first requester after the last owner, scanning upward with wrap
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IDW'((int'(last) + i) % N);
            if (bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
    // next-state: hold or release the owner in GRANT, arbitrate otherwise
    always_comb begin
        state_n   = state;
        count_n   = count;
        last_n    = last;
        owner_n   = owner;
        grant_n   = grant;
        expired_n = 1'b0;
        if (state == GRANT) begin
            if (release_now || (quantum_end && others)) begin
                state_n   = GAP;
                grant_n   = '0;
                last_n    = owner;
                expired_n = !release_now;
            end else begin
                count_n = quantum_end ? '0 : count + 1'b1;
            end
        end else if (found) begin
            state_n = GRANT;
            grant_n = N'(1) << winner;
            owner_n = winner;
            count_n = '0;
        end else begin
            state_n = IDLE;
        end
    end
    // state and registered outputs; pointer resets so requester 0 goes first
    always_ff @(posedge cin) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            last    <= IDW'(N - 1);
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            last    <= last_n;
            owner   <= owner_n;
            grant   <= grant_n;
            busy    <= |grant_n;
            expired <= expired_n;
        end
    end
    assign bus.grant   = grant;
    assign bus.owner   = owner;
    assign bus.busy    = busy;
    assign bus.expired = expired;
endmodule
